// File: rtl/rx_controller.sv
// Two-segment remote-switch receiver: pairs segment-1/segment-2 UART bytes into demod outputs,
// flagging protocol errors and segment-2 timeouts.
module rx_controller #(
  parameter int TIMEOUT = 100000,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             frame_err,
  output logic             demod_1,
  output logic             demod_2,
  output logic             update,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT_SEG2 = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             hold_1_q, hold_1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             demod_1_q, demod_1_d;
  logic             demod_2_q, demod_2_d;
  logic             update_q, update_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic is_seg1, is_seg2, byte_ok;

  assign is_seg1 = (rx_data[7:6] == 2'b01);
  assign is_seg2 = (rx_data[7:6] == 2'b10);
  assign byte_ok = !frame_err && (is_seg1 || is_seg2) && (rx_data[5:1] == 5'd0);

  always_comb begin
    state_d     = state_q;
    hold_1_d    = hold_1_q;
    cnt_d       = cnt_q;
    demod_1_d   = demod_1_q;
    demod_2_d   = demod_2_q;
    update_d    = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    // An arriving byte always wins over the timeout check in the same cycle.
    if (rx_valid) begin
      if (!byte_ok) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (is_seg1) begin
        err_d    = (state_q == WAIT_SEG2);
        hold_1_d = rx_data[0];
        cnt_d    = '0;
        state_d  = WAIT_SEG2;
      end else if (state_q == WAIT_SEG2) begin
        demod_1_d = hold_1_q;
        demod_2_d = rx_data[0];
        update_d  = 1'b1;
        state_d   = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == WAIT_SEG2) begin
      if (cnt_q == CNT_MAX) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (err_d && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_1_q    <= 1'b0;
      cnt_q       <= '0;
      demod_1_q   <= 1'b0;
      demod_2_q   <= 1'b0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_1_q    <= hold_1_d;
      cnt_q       <= cnt_d;
      demod_1_q   <= demod_1_d;
      demod_2_q   <= demod_2_d;
      update_q    <= update_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign demod_1   = demod_1_q;
  assign demod_2   = demod_2_q;
  assign update    = update_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign busy      = (state_q == WAIT_SEG2);

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller with a short timeout; inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_rx_controller;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       demod_1, demod_2, update, err, busy;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  rx_controller #(.TIMEOUT(TO), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .demod_1   (demod_1),
    .demod_2   (demod_2),
    .update    (update),
    .err       (err),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input logic fe);
    rx_valid  = 1'b1;
    rx_data   = d;
    frame_err = fe;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    frame_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic d1, input logic d2, input logic upd,
                            input logic er, input logic [7:0] cnt, input logic bsy);
    check({tag, ".demod_1"}, 32'(demod_1), 32'(d1));
    check({tag, ".demod_2"}, 32'(demod_2), 32'(d2));
    check({tag, ".update"}, 32'(update), 32'(upd));
    check({tag, ".err"}, 32'(err), 32'(er));
    check({tag, ".err_count"}, 32'(err_count), 32'(cnt));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_err = 1'b0;
    idle(2);
    rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 8'd0, 0);

    // Basic pair, 10 cycles apart
    strobe(8'h41, 1'b0);
    check_outs("seg1", 0, 0, 0, 0, 8'd0, 1);
    idle(9);
    strobe(8'h80, 1'b0);
    check_outs("pair", 1, 0, 1, 0, 8'd0, 0);
    idle(1);
    check("pair.update_once", 32'(update), 32'd0);

    // Segment 2 in IDLE
    strobe(8'h81, 1'b0);
    check_outs("seg2_idle", 1, 0, 0, 1, 8'd1, 0);
    idle(1);
    check("seg2_idle.err_once", 32'(err), 32'd0);

    // Timeout: no err after TO-1 idle cycles, err on the TO-th
    strobe(8'h40, 1'b0);
    check("to.busy", 32'(busy), 32'd1);
    idle(TO - 1);
    check_outs("to.before", 1, 0, 0, 0, 8'd1, 1);
    idle(1);
    check_outs("to.fire", 1, 0, 0, 1, 8'd2, 0);
    strobe(8'h81, 1'b0);
    check_outs("to.after_seg2", 1, 0, 0, 1, 8'd3, 0);

    // Resync on repeated segment 1
    strobe(8'h41, 1'b0);
    check_outs("resync.seg1", 1, 0, 0, 0, 8'd3, 1);
    strobe(8'h40, 1'b0);
    check_outs("resync.again", 1, 0, 0, 1, 8'd4, 1);
    strobe(8'h81, 1'b0);
    check_outs("resync.pair", 0, 1, 1, 0, 8'd4, 0);

    // Byte on the timeout cycle wins
    strobe(8'h41, 1'b0);
    idle(TO - 1);
    strobe(8'h80, 1'b0);
    check_outs("to_edge.pair", 1, 0, 1, 0, 8'd4, 0);

    // Reserved bits set while waiting, bad id in IDLE
    strobe(8'h41, 1'b0);
    strobe(8'h43, 1'b0);
    check_outs("reserved", 1, 0, 0, 1, 8'd5, 0);
    strobe(8'hC1, 1'b0);
    check_outs("bad_id", 1, 0, 0, 1, 8'd6, 0);

    // Frame error mid-pair, then saturation
    strobe(8'h41, 1'b0);
    strobe(8'h81, 1'b1);
    check_outs("frame_err", 1, 0, 0, 1, 8'd7, 0);
    for (int i = 0; i < 300; i++) strobe(8'h81, 1'b1);
    check_outs("saturate", 1, 0, 0, 1, 8'd255, 0);

    // Reset in mid-pair
    strobe(8'h41, 1'b0);
    check("rst_mid.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_outs("rst_mid", 0, 0, 0, 0, 8'd0, 0);
    strobe(8'h80, 1'b0);
    check_outs("rst_mid.seg2", 0, 0, 0, 1, 8'd1, 0);

    // Reset wins over a segment-2 byte on the same edge
    strobe(8'h41, 1'b0);
    rst = 1'b1;
    strobe(8'h81, 1'b0);
    rst = 1'b0;
    check_outs("rst_prio", 0, 0, 0, 0, 8'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_controller.md
RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 Parameter TIMEOUT, default 100000, is the number of clk cycles allowed between segment 1 and segment 2.
REQ-002 Parameter ERR_W, default 8, is the width of the error counter.
REQ-003 clk  input  1  system clock; every register is updated on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rx_valid  input  1  one-cycle strobe from the UART receiver marking a received byte on rx_data.
REQ-006 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-007 frame_err  input  1  stop-bit error for the current byte; sampled only when rx_valid=1.
REQ-008 demod_1  output  1  reconstructed remote switch 1 state.
REQ-009 demod_2  output  1  reconstructed remote switch 2 state.
REQ-010 update  output  1  one-cycle pulse when demod_1 and demod_2 have just been loaded from a complete pair.
REQ-011 err  output  1  one-cycle pulse on any protocol error.
REQ-012 err_count  output  ERR_W  saturating count of err pulses.
REQ-013 busy  output  1  high while the block waits for segment 2.

Function
REQ-014 Byte format SHALL be: bits[7:6] = segment id (01 = segment 1, 10 = segment 2), bits[5:1] = 0, bit[0] = switch value.
REQ-015 A byte SHALL be valid only when rx_valid=1, frame_err=0, id is 01 or 10, and bits[5:1]=0.
REQ-016 The FSM SHALL have exactly two states: IDLE and WAIT_SEG2; busy=1 only in WAIT_SEG2.
REQ-017 In IDLE, a valid segment-1 byte SHALL store bit[0] in hold_1, clear the timeout counter, and move to WAIT_SEG2.
REQ-018 In WAIT_SEG2, a valid segment-2 byte SHALL load demod_1 <= hold_1 and demod_2 <= bit[0], pulse update, and return to IDLE.
REQ-019 The registers in REQ-018 SHALL be written on the edge that samples rx_valid, so the new values are visible one cycle after the rx_valid cycle.
REQ-020 update SHALL pulse on every completed pair, including a pair whose values equal the current outputs.
REQ-021 In IDLE, a valid segment-2 byte SHALL be discarded with an err pulse; the state stays IDLE.
REQ-022 In WAIT_SEG2, a valid segment-1 byte SHALL pulse err, overwrite hold_1, restart the timeout counter, and stay in WAIT_SEG2 (resync).
REQ-023 An invalid byte (frame_err=1, bad id, or nonzero reserved bits) SHALL pulse err and force IDLE from either state; demod outputs do not change.
REQ-024 In WAIT_SEG2, the timeout counter SHALL increment on every cycle with rx_valid=0.
REQ-025 When the timeout counter equals TIMEOUT-1 and rx_valid=0, the next edge SHALL pulse err and return to IDLE.
REQ-026 A byte arriving on the same cycle as the timeout condition SHALL take priority over the timeout.
REQ-027 The timeout counter SHALL be $clog2(TIMEOUT) bits wide and SHALL never wrap.
REQ-028 err_count SHALL increment on each err pulse and saturate at all-ones.
REQ-029 At most one err pulse SHALL occur per cycle.
REQ-030 update and err SHALL never be high in the same cycle.
REQ-031 demod_1 and demod_2 SHALL hold their values in every case except REQ-018.

Reset
REQ-032 When rst=1 on a clock edge, the block SHALL set: state=IDLE, demod_1=0, demod_2=0, update=0, err=0, err_count=0, busy=0, hold_1=0, timeout counter=0.
REQ-033 rst SHALL take priority over every other input on the same edge, including a byte in mid-pair.

Verification
REQ-034 Bytes 0x41 then 0x80, 10 cycles apart -> one cycle after the 0x80 strobe: demod_1=1, demod_2=0, update pulses once, err=0.
REQ-035 Byte 0x81 in IDLE -> err pulses once, err_count=1, state stays IDLE, demod outputs unchanged.
REQ-036 0x40, then no byte for TIMEOUT cycles -> err pulses once, busy falls; a following 0x81 alone produces err, not update.
REQ-037 0x41, then 0x40, then 0x81 -> err pulses once (resync), then update with demod_1=0, demod_2=1.
REQ-038 0x41, then 0x81 with frame_err=1 -> err pulses, state is IDLE, no update; repeating the error 300 times -> err_count=255.
REQ-039 0x41 accepted, then rst=1 for 1 cycle, then 0x80 -> all outputs are reset values and the 0x80 produces err, not update.
